// File: rtl/boot_loader.sv
// boot_loader: streams a little-endian program image from a byte receiver into
// word-addressed memory while holding the RV32I core in reset, then releases
// the core and passes its bus straight through to memory.
// Build option: define BOOT_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the payload before the core is released.
module boot_loader #(
    parameter int MEM_WORDS     = 16384,
    parameter int BASE_WORD     = 0,
    parameter int RELEASE_DELAY = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        cpu_reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_data_w,
    input  logic [3:0]  cpu_mask_w,
    input  logic        cpu_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_w,
    output logic [3:0]  mem_mask_w,
    output logic        mem_write,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        ST_HEADER,
        ST_PAYLOAD,
        ST_CHECK,
        ST_RELEASE,
        ST_RUN,
        ST_ERROR
    } state_t;

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_PAYLOAD = ST_CHECK;
`else
    localparam state_t ST_AFTER_PAYLOAD = ST_RELEASE;
`endif

    state_t      state_reg, state_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [31:0] word_cnt_reg, word_cnt_next;
    logic [31:0] n_reg, n_next;
    logic [31:0] rel_cnt_reg, rel_cnt_next;
    logic        ld_write_reg, ld_write_next;
    logic [31:0] ld_addr_reg, ld_addr_next;
    logic [31:0] ld_data_reg, ld_data_next;
    logic [3:0]  ld_mask_reg, ld_mask_next;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  csum_reg, csum_next;
`endif

    logic [7:0]  asm_reg  [4];
    logic [7:0]  asm_next [4];
    logic [31:0] asm_word;
    logic        rx_accept;

    // Byte is taken only while the loader is still consuming the stream
    assign rx_ready  = (state_reg == ST_HEADER) || (state_reg == ST_PAYLOAD) ||
                       (state_reg == ST_CHECK);
    assign rx_accept = rx_valid && rx_ready;

    // Full word as it will look once the current byte (the 4th) is added
    assign asm_word  = {rx_data, asm_reg[2], asm_reg[1], asm_reg[0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign asm_next[gi] = (rx_accept && (byte_cnt_reg == 2'(gi))) ? rx_data : asm_reg[gi];

            // Each byte lane captures the incoming byte when it is its turn
            always_ff @(posedge clock) begin
                if (reset) begin
                    asm_reg[gi] <= '0;
                end else begin
                    asm_reg[gi] <= asm_next[gi];
                end
            end
        end
    endgenerate

    // State register and load-side datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_HEADER;
            byte_cnt_reg <= '0;
            word_cnt_reg <= '0;
            n_reg        <= '0;
            rel_cnt_reg  <= '0;
            ld_write_reg <= 1'b0;
            ld_addr_reg  <= '0;
            ld_data_reg  <= '0;
            ld_mask_reg  <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_reg     <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            word_cnt_reg <= word_cnt_next;
            n_reg        <= n_next;
            rel_cnt_reg  <= rel_cnt_next;
            ld_write_reg <= ld_write_next;
            ld_addr_reg  <= ld_addr_next;
            ld_data_reg  <= ld_data_next;
            ld_mask_reg  <= ld_mask_next;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_reg     <= csum_next;
`endif
        end
    end

    // Next-state logic: header parse, word assembly/write, release countdown
    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        word_cnt_next = word_cnt_reg;
        n_next        = n_reg;
        rel_cnt_next  = '0;
        ld_write_next = 1'b0;
        ld_addr_next  = ld_addr_reg;
        ld_data_next  = ld_data_reg;
        ld_mask_next  = ld_mask_reg;
`ifdef BOOT_LOADER_CHECKSUM_EN
        csum_next     = csum_reg;
`endif
        case (state_reg)
            ST_HEADER: begin
                if (rx_accept) begin
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        n_next        = asm_word;
                        word_cnt_next = '0;
                        if (asm_word > 32'(MEM_WORDS)) begin
                            state_next = ST_ERROR;
                        end else if (asm_word == 32'd0) begin
                            state_next = ST_AFTER_PAYLOAD;
                        end else begin
                            state_next = ST_PAYLOAD;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_accept) begin
                    byte_cnt_next = byte_cnt_reg + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    csum_next     = csum_reg ^ rx_data;
`endif
                    if (byte_cnt_reg == 2'd3) begin
                        ld_write_next = 1'b1;
                        ld_addr_next  = 32'(BASE_WORD) + word_cnt_reg;
                        ld_data_next  = asm_word;
                        ld_mask_next  = 4'b1111;
                        word_cnt_next = word_cnt_reg + 32'd1;
                        if (word_cnt_reg == n_reg - 32'd1) begin
                            state_next = ST_AFTER_PAYLOAD;
                        end
                    end
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (rx_accept) begin
                    state_next = (rx_data == csum_reg) ? ST_RELEASE : ST_ERROR;
                end
            end
`endif
            ST_RELEASE: begin
                rel_cnt_next = rel_cnt_reg + 32'd1;
                if (rel_cnt_reg == 32'(RELEASE_DELAY - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
            end
            ST_ERROR: begin
            end
            default: begin
                state_next = ST_ERROR;
            end
        endcase
    end

    // Memory port: core bus passes through untouched in RUN, loader owns it otherwise
    always_comb begin
        if (state_reg == ST_RUN) begin
            mem_addr   = cpu_addr;
            mem_data_w = cpu_data_w;
            mem_mask_w = cpu_mask_w;
            mem_write  = cpu_write;
        end else begin
            mem_addr   = ld_addr_reg;
            mem_data_w = ld_data_reg;
            mem_mask_w = ld_mask_reg;
            mem_write  = ld_write_reg && (state_reg != ST_ERROR);
        end
    end

    assign cpu_reset = (state_reg != ST_RUN);
    assign done      = (state_reg == ST_RUN);
    assign error     = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: loads images into boot_loader and checks the observed write
// stream, handshake and release timing against an image-level expectation.
module tb_boot_loader;

    localparam int MW = 64;
    localparam int BW = 0;
    localparam int RD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        cpu_reset;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_data_w = '0;
    logic [3:0]  cpu_mask_w = '0;
    logic        cpu_write = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_w;
    logic [3:0]  mem_mask_w;
    logic        mem_write;
    logic        done;
    logic        error;

    boot_loader #(.MEM_WORDS(MW), .BASE_WORD(BW), .RELEASE_DELAY(RD)) dut (
        .clock(clock), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .cpu_reset(cpu_reset),
        .cpu_addr(cpu_addr), .cpu_data_w(cpu_data_w), .cpu_mask_w(cpu_mask_w), .cpu_write(cpu_write),
        .mem_addr(mem_addr), .mem_data_w(mem_data_w), .mem_mask_w(mem_mask_w), .mem_write(mem_write),
        .done(done), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        wr;
        logic        rxv;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_mask;
        logic        e_wr;
        logic        e_rdy;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cyc = -1;
    int          err_cyc = -1;
    wr_t         wq[$];
    int          acc_q[$];
    logic [31:0] img[$];
    logic [7:0]  tx_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Observe accepted bytes, loader writes and status edges
    always @(negedge clock) begin
        if (!reset) begin
            if (rx_valid && rx_ready) acc_q.push_back(cyc);
            if (mem_write && !done) wq.push_back('{mem_addr, mem_data_w, mem_mask_w, cyc});
            if (done && done_cyc < 0) done_cyc = cyc;
            if (error && err_cyc < 0) err_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        wq.delete();
        acc_q.delete();
        done_cyc = -1;
        err_cyc = -1;
    endtask

    task automatic do_reset(input bit check_state);
        reset = 1'b1;
        rx_valid = 1'b0;
        tick();
        tick();
        if (check_state) begin
            @(negedge clock);
            chk("rst_cpu_reset", cpu_reset, 1);
            chk("rst_mem_write", mem_write, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_data", mem_data_w, 0);
            chk("rst_mem_mask", mem_mask_w, 0);
            chk("rst_done", done, 0);
            chk("rst_error", error, 0);
            chk("rst_rx_ready", rx_ready, 1);
            tick();
        end
        reset = 1'b0;
        clear_obs();
    endtask

    function automatic logic [7:0] img_csum();
        logic [7:0] x;
        x = 8'h00;
        foreach (img[i]) begin
            for (int b = 0; b < 4; b++) x = x ^ img[i][8*b +: 8];
        end
        return x;
    endfunction

    // Byte stream for the image in img: header count, payload, optional checksum
    task automatic build_tx(input int n, input bit bad_csum);
        logic [31:0] nw;
        logic [7:0]  cs;
        nw = 32'(n);
        tx_q.delete();
        for (int b = 0; b < 4; b++) tx_q.push_back(nw[8*b +: 8]);
        foreach (img[i]) begin
            for (int b = 0; b < 4; b++) tx_q.push_back(img[i][8*b +: 8]);
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        cs = img_csum();
        if (bad_csum) cs = (cs == 8'hFF) ? 8'h00 : 8'hFF;
        tx_q.push_back(cs);
`else
        cs = 8'h00;
        if (bad_csum) cs = 8'h01;
`endif
    endtask

    task automatic send_bytes(input bit gaps, output int stalls);
        int tries;
        bit got;
        stalls = 0;
        foreach (tx_q[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    rx_valid = 1'b0;
                    rx_data = 8'($urandom);
                    tick();
                end
            end
            rx_valid = 1'b1;
            rx_data = tx_q[i];
            tries = 0;
            got = 1'b0;
            while (!got) begin
                @(negedge clock);
                got = rx_ready;
                tick();
                if (!got) begin
                    stalls++;
                    tries++;
                    if (tries > 20) begin
                        chk("rx_accept_timeout", 0, 1);
                        rx_valid = 1'b0;
                        return;
                    end
                end
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_end();
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (done || error) begin
                tick();
                return;
            end
            tick();
        end
    endtask

    // Check the write stream produced by the image in img
    task automatic check_writes(input string tag, input int n);
        chk({tag, "_wr_count"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            chk({tag, "_wr_addr"}, wq[i].addr, 32'(BW + i));
            chk({tag, "_wr_data"}, wq[i].data, img[i]);
            chk({tag, "_wr_mask"}, wq[i].mask, 4'hF);
            if (acc_q.size() > 4 * i + 7)
                chk({tag, "_wr_latency"}, wq[i].cyc, acc_q[4 * i + 7] + 1);
        end
    endtask

    task automatic run_image(input string tag, input int n, input bit gaps, input bit bad_csum);
        int  stalls;
        bit  exp_err;
        build_tx(n, bad_csum);
        do_reset(0);
        cpu_write = 1'b1;
        cpu_addr = $urandom;
        cpu_data_w = $urandom;
        cpu_mask_w = 4'hF;
        send_bytes(gaps, stalls);
        wait_end();
        cpu_write = 1'b0;
        check_writes(tag, n);
        if (!gaps) chk({tag, "_stalls"}, stalls, 0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        exp_err = bad_csum;
`else
        exp_err = 1'b0;
`endif
        @(negedge clock);
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_done"}, done, !exp_err);
        chk({tag, "_cpu_reset"}, cpu_reset, exp_err);
        chk({tag, "_rx_ready_end"}, rx_ready, 0);
        tick();
        if (!exp_err) begin
            chk({tag, "_bytes_taken"}, acc_q.size(), tx_q.size());
            if (acc_q.size() > 0)
                chk({tag, "_release_time"}, done_cyc, acc_q[acc_q.size() - 1] + 1 + RD);
`ifndef BOOT_LOADER_CHECKSUM_EN
            if (n > 0 && wq.size() > 0)
                chk({tag, "_write_to_run"}, done_cyc - wq[wq.size() - 1].cyc, RD);
`endif
        end
        $display("image %s: n=%0d writes=%0d done=%0b error=%0b", tag, n, wq.size(), done, error);
    endtask

    vec_t vecs[4];

    initial begin
        int stalls;
        int acc_before;

        vecs[0] = '{32'h40, 32'hDEADBEEF, 4'b0011, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'b0011, 1'b1, 1'b0};
        vecs[1] = '{32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h12345678, 4'hF, 1'b1, 1'b0};
        vecs[3] = '{32'h1234, 32'hA5A5A5A5, 4'h8, 1'b0, 1'b1, 32'h1234, 32'hA5A5A5A5, 4'h8, 1'b0, 1'b0};

        cpu_write = 1'b1;
        cpu_addr = 32'h55;
        cpu_data_w = 32'h77;
        cpu_mask_w = 4'hF;
        do_reset(1);

        // Reference image, then core bus passthrough in RUN
        img = '{32'h00000513, 32'h00100073};
        run_image("spec", 2, 0, 0);
        acc_before = acc_q.size();
        for (int i = 0; i < 4; i++) begin
            cpu_addr = vecs[i].addr;
            cpu_data_w = vecs[i].data;
            cpu_mask_w = vecs[i].mask;
            cpu_write = vecs[i].wr;
            rx_valid = vecs[i].rxv;
            rx_data = 8'h5A;
            @(negedge clock);
            chk("run_addr", mem_addr, vecs[i].e_addr);
            chk("run_data", mem_data_w, vecs[i].e_data);
            chk("run_mask", mem_mask_w, vecs[i].e_mask);
            chk("run_write", mem_write, vecs[i].e_wr);
            chk("run_rx_ready", rx_ready, vecs[i].e_rdy);
            $display("run vec %0d: addr=%h data=%h mask=%h wr=%0b", i, mem_addr, mem_data_w, mem_mask_w, mem_write);
            tick();
        end
        rx_valid = 1'b0;
        cpu_write = 1'b0;
        chk("run_rx_ignored", acc_q.size(), acc_before);

        // Reset during RUN holds the core again
        reset = 1'b1;
        tick();
        @(negedge clock);
        chk("rerun_cpu_reset", cpu_reset, 1);
        chk("rerun_done", done, 0);
        tick();

        img.delete();
        run_image("n0", 0, 0, 0);

        for (int i = 0; i < MW; i++) img.push_back($urandom);
        run_image("nmax", MW, 0, 0);

`ifdef BOOT_LOADER_CHECKSUM_EN
        img = '{32'h00000513, 32'h00100073};
        run_image("badcs", 2, 0, 1);
`endif

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 8);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            run_image("rand", n, r[0], 0);
        end

        // Oversized header: error after the 4th byte, nothing written
        img.delete();
        tx_q.delete();
        begin
            logic [31:0] big;
            big = 32'(MW + 1);
            for (int b = 0; b < 4; b++) tx_q.push_back(big[8*b +: 8]);
        end
        do_reset(0);
        send_bytes(0, stalls);
        @(negedge clock);
        chk("big_error", error, 1);
        chk("big_cpu_reset", cpu_reset, 1);
        chk("big_rx_ready", rx_ready, 0);
        tick();
        tick();
        tick();
        chk("big_err_time", err_cyc, (acc_q.size() == 4) ? acc_q[3] + 1 : -2);
        chk("big_no_write", wq.size(), 0);
        $display("image big: error=%0b writes=%0d", error, wq.size());

        // Reset part-way through word 1 discards it; a fresh header loads cleanly
        img = '{32'h11223344, 32'hAABBCCDD};
        build_tx(2, 0);
        while (tx_q.size() > 10) void'(tx_q.pop_back());
        do_reset(0);
        send_bytes(0, stalls);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        @(negedge clock);
        chk("midrst_rx_ready", rx_ready, 1);
        chk("midrst_wr_count", wq.size(), 1);
        if (wq.size() > 0) chk("midrst_wr_data", wq[0].data, 32'h11223344);
        tick();
        clear_obs();
        img = '{32'hCAFEF00D};
        build_tx(1, 0);
        send_bytes(0, stalls);
        wait_end();
        check_writes("reload", 1);
        @(negedge clock);
        chk("reload_done", done, 1);
        $display("image reload: writes=%0d done=%0b", wq.size(), done);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL global_timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
